align_operands: RTL and testbench

ALIGN_OPERANDS -- requirements
Module: align_operands

---
 rtl/align_operands.sv | 178 +++++++++++++++++
 tb/tb_align_operands.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/align_operands.sv
// -----------------------------------------------------------------------------
// align_operands
//
// Purpose:
//   Front end of a single-precision floating-point adder. It accepts an
//   operand pair, unpacks both operands into 25-bit significands and orders
//   them by magnitude. It then right-aligns the smaller significand to the
//   larger exponent, one bit per cycle, and presents the aligned pair with a
//   sticky bit. That sticky bit collects every bit shifted out of the
//   smaller significand.
//
// Ports:
//   clk               in   1   rising-edge clock
//   rst               in   1   synchronous active-high reset
//   in_valid          in   1   operand pair a/b valid
//   in_ready          out  1   block can accept a pair (IDLE, rst low)
//   a, b              in   32  IEEE-754 single-precision operands
//   out_valid         out  1   aligned result valid (DONE state)
//   out_ready         in   1   downstream accepts the result
//   significand_big   out  25  significand of larger-magnitude operand
//   significand_small out  25  smaller significand, right-aligned
//   exponent          out  8   larger biased exponent
//   op                out  1   0 add, 1 subtract (sign XOR)
//   sign              out  1   sign of larger-magnitude operand
//   sticky            out  1   OR of all bits shifted out of the small side
//
// Parameter:
//   SHIFT_CAP  exponent difference at or above which the small significand
//              is flushed to zero in one step. The legal range is 1..256.
// -----------------------------------------------------------------------------
module align_operands #(
  parameter int SHIFT_CAP = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] significand_big,
  output logic [24:0] significand_small,
  output logic [7:0]  exponent,
  output logic        op,
  output logic        sign,
  output logic        sticky
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // 9 bits so that a cap of 256 (never flush) is still representable.
  localparam logic [8:0] CAP9 = SHIFT_CAP[8:0];

  state_e      state_q,  state_d;
  logic [7:0]  cnt_q,    cnt_d;
  logic [24:0] big_q,    big_d;
  logic [24:0] small_q,  small_d;
  logic [7:0]  exp_q,    exp_d;
  logic        op_q,     op_d;
  logic        sign_q,   sign_d;
  logic        sticky_q, sticky_d;

  logic        swap_s;
  logic [31:0] opb_s;      // larger-magnitude operand
  logic [31:0] ops_s;      // smaller-magnitude operand
  logic [24:0] sig_big_s;
  logic [24:0] sig_small_s;
  logic [7:0]  diff_s;

  // Unpack and order the incoming pair by magnitude.
  always_comb begin
    // Comparing {exponent,fraction} as one unsigned field orders by exponent
    // first and then by fraction. A strict compare makes A the winner on a tie.
    swap_s      = (b[30:0] > a[30:0]);
    opb_s       = swap_s ? b : a;
    ops_s       = swap_s ? a : b;
    sig_big_s   = {1'b0, (opb_s[30:23] != 8'd0), opb_s[22:0]};
    sig_small_s = {1'b0, (ops_s[30:23] != 8'd0), ops_s[22:0]};
    diff_s      = opb_s[30:23] - ops_s[30:23];
  end

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    big_d    = big_q;
    small_d  = small_q;
    exp_d    = exp_q;
    op_d     = op_q;
    sign_d   = sign_q;
    sticky_d = sticky_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          big_d    = sig_big_s;
          exp_d    = opb_s[30:23];
          op_d     = a[31] ^ b[31];
          sign_d   = opb_s[31];
          sticky_d = 1'b0;
          cnt_d    = 8'd0;
          if ({1'b0, diff_s} >= CAP9) begin
            // Everything would fall off the end, so flush in one step.
            small_d  = 25'd0;
            sticky_d = (sig_small_s != 25'd0);
            state_d  = DONE;
          end else if (diff_s == 8'd0) begin
            small_d = sig_small_s;
            state_d = DONE;
          end else begin
            small_d = sig_small_s;
            cnt_d   = diff_s;
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        small_d  = {1'b0, small_q[24:1]};
        sticky_d = sticky_q | small_q[0];
        cnt_d    = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      big_q    <= 25'd0;
      small_q  <= 25'd0;
      exp_q    <= 8'd0;
      op_q     <= 1'b0;
      sign_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      big_q    <= big_d;
      small_q  <= small_d;
      exp_q    <= exp_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      sticky_q <= sticky_d;
    end
  end

  assign in_ready          = (state_q == IDLE) && !rst;
  assign out_valid         = (state_q == DONE);
  assign significand_big   = big_q;
  assign significand_small = small_q;
  assign exponent          = exp_q;
  assign op                = op_q;
  assign sign              = sign_q;
  assign sticky            = sticky_q;

endmodule

// File: tb/tb_align_operands.sv
// -----------------------------------------------------------------------------
// tb_align_operands
//
// Purpose:
//   Self-checking bench for align_operands. It runs directed vectors, a
//   backpressure case, a reset in the middle of a shift, and random operand
//   pairs. Expected values come either from literal constants or from an
//   arithmetic reference model of the alignment rules.
// -----------------------------------------------------------------------------
module tb_align_operands;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] significand_big;
  logic [24:0] significand_small;
  logic [7:0]  exponent;
  logic        op;
  logic        sign;
  logic        sticky;

  int total;
  int bad;

  align_operands #(.SHIFT_CAP(25)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .a                 (a),
    .b                 (b),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .significand_big   (significand_big),
    .significand_small (significand_small),
    .exponent          (exponent),
    .op                (op),
    .sign              (sign),
    .sticky            (sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: magnitude ordering, then the small significand divided by
  // 2^d, with the remainder being nonzero giving sticky.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb,
                       output logic [24:0] eb, output logic [24:0] es,
                       output logic [7:0] ee, output logic eop,
                       output logic esg, output logic est, output int elat);
    longint unsigned mag_a, mag_b, sb, ss, dv;
    logic [31:0] x, y;
    int d;
    mag_a = longint'(ma[30:0]);
    mag_b = longint'(mb[30:0]);
    if (mag_b > mag_a) begin x = mb; y = ma; end
    else begin x = ma; y = mb; end
    sb = longint'(x[22:0]) + ((x[30:23] != 8'd0) ? 64'd8388608 : 64'd0);
    ss = longint'(y[22:0]) + ((y[30:23] != 8'd0) ? 64'd8388608 : 64'd0);
    d  = int'(x[30:23]) - int'(y[30:23]);
    eb  = sb[24:0];
    ee  = x[30:23];
    eop = ma[31] ^ mb[31];
    esg = x[31];
    if (d >= 25) begin
      es   = 25'd0;
      est  = (ss != 64'd0);
      elat = 1;
    end else begin
      dv   = 64'd1 << d;
      dv   = ss / dv;
      es   = dv[24:0];
      est  = ((ss % (64'd1 << d)) != 64'd0);
      elat = 1 + d;
    end
  endtask

  // One full transaction: accept, wait for the result, check it, hold it
  // under backpressure with a competing in_valid, then release.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                        input logic [24:0] eb, input logic [24:0] es,
                        input logic [7:0] ee, input logic eop, input logic esg,
                        input logic est, input int elat, input int hold);
    int lat;
    chk({tag, " in_ready_pre"}, {31'd0, in_ready}, 32'd1);
    a        = ta;
    b        = tbv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    lat      = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, elat);
    chk({tag, " big"},    {7'd0, significand_big},   {7'd0, eb});
    chk({tag, " small"},  {7'd0, significand_small}, {7'd0, es});
    chk({tag, " exp"},    {24'd0, exponent}, {24'd0, ee});
    chk({tag, " op"},     {31'd0, op},     {31'd0, eop});
    chk({tag, " sign"},   {31'd0, sign},   {31'd0, esg});
    chk({tag, " sticky"}, {31'd0, sticky}, {31'd0, est});
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      a        = $urandom;
      b        = $urandom;
      chk({tag, " hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      chk({tag, " hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, " hold_big"},   {7'd0, significand_big},   {7'd0, eb});
      chk({tag, " hold_small"}, {7'd0, significand_small}, {7'd0, es});
      chk({tag, " hold_misc"},
          {21'd0, exponent, op, sign, sticky},
          {21'd0, ee, eop, esg, est});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " post_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " post_ready"}, {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    logic [24:0] eb, es;
    logic [7:0]  ee;
    logic        eop, esg, est;
    int          elat;
    logic [7:0]  ea_e, eb_e;
    logic [31:0] ra, rb;
    bit          seen;
    int          de;

    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 32'd0;
    b         = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready},  32'd0);
    chk("rst_valid",    {31'd0, out_valid}, 32'd0);
    chk("rst_outs", {significand_big[6:0], significand_small, exponent == 8'd0 ? 1'b0 : 1'b1,
                     op | sign | sticky | (significand_big[24:7] != 18'd0)}, 32'd0);
    chk("rst_exp", {24'd0, exponent}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed vectors
    run_op("add_shift1", 32'h3F800000, 32'h40000000,
           25'h0800000, 25'h0400000, 8'h80, 1'b0, 1'b0, 1'b0, 2, 0);
    run_op("eq_sub", 32'h3F800000, 32'hBFC00000,
           25'h0C00000, 25'h0800000, 8'h7F, 1'b1, 1'b1, 1'b0, 1, 0);
    run_op("swap_cap", 32'h3F800000, 32'h4E800000,
           25'h0800000, 25'h0000000, 8'h9D, 1'b0, 1'b0, 1'b1, 1, 0);
    run_op("long_shift", 32'h4B800000, 32'h3F800001,
           25'h0800000, 25'h0000000, 8'h97, 1'b0, 1'b0, 1'b1, 25, 0);
    run_op("backpressure", 32'h3F800000, 32'h40000000,
           25'h0800000, 25'h0400000, 8'h80, 1'b0, 1'b0, 1'b0, 2, 5);
    // Full tie: A is big, sign from A.
    run_op("tie", 32'hC0400000, 32'h40400000,
           25'h0C00000, 25'h0C00000, 8'h80, 1'b1, 1'b1, 1'b0, 1, 0);
    // Denormal small side, d = 1 with a one shifted out.
    run_op("denorm", 32'h00800000, 32'h00000003,
           25'h0800000, 25'h0000001, 8'h01, 1'b0, 1'b0, 1'b1, 2, 0);

    // Reset in the middle of a shift
    a        = 32'h4B800000;
    b        = 32'h3F800001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_big",   {7'd0, significand_big},   32'd0);
    chk("abort_small", {7'd0, significand_small}, 32'd0);
    chk("abort_misc",  {21'd0, exponent, op, sign, sticky}, 32'd0);
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_valid", {31'd0, seen}, 32'd0);

    // Random pairs with exponents near each other
    for (int n = 0; n < 40; n++) begin
      ea_e = 8'($urandom_range(1, 250));
      de   = int'($urandom_range(0, 32)) - 16;
      if (int'(ea_e) + de < 0) eb_e = 8'd0;
      else if (int'(ea_e) + de > 254) eb_e = 8'd254;
      else eb_e = 8'(int'(ea_e) + de);
      if (n % 9 == 4) eb_e = 8'd0;
      ra = {1'($urandom), ea_e, 23'($urandom)};
      rb = {1'($urandom), eb_e, 23'($urandom)};
      if (n % 11 == 7) rb = {~ra[31], ra[30:0]};
      model(ra, rb, eb, es, ee, eop, esg, est, elat);
      run_op($sformatf("rand%0d", n), ra, rb, eb, es, ee, eop, esg, est, elat,
             int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
